// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative signed/unsigned multiply, multiply-accumulate and restoring divide, plus MTHI/MTLO.
// Latency: MTHI/MTLO and divide-by-zero finish at the Start edge; others take 33 edges (multiplies 1 edge with FAST_MULT_EN).
// No backpressure: Start is accepted only while Busy=0; a Start during Busy is dropped.
// Optional feature macro: FAST_MULT_EN (single-cycle native multiply for MULT/MULTU/MADD/MSUB).
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int DW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;      // multiplicand or divisor magnitude
    logic [DW-1:0]    prod_q, prod_d;    // product, or {remainder, quotient} while dividing
    logic             neg_q, neg_d;      // negate product / quotient
    logic             neg_r_q, neg_r_d;  // negate remainder
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    // Operand preparation at the Start edge: signed ops work on magnitudes.
    logic             op_signed, op_is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign op_is_div = (Op == OP_DIV) || (Op == OP_DIVU);
    assign a_neg     = op_signed && A[WIDTH-1];
    assign b_neg     = op_signed && B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // One iteration step for each algorithm.
    logic [WIDTH:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, prod_q[DW-1:WIDTH]} + (prod_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {prod_q[DW-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    // Sign-corrected results used in FIXUP.
    logic [DW-1:0]    hilo, prod_s;
    logic [WIDTH-1:0] quot_f, rem_f;
    assign hilo   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod_q : prod_q;
    assign quot_f = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_f  = neg_r_q ? -prod_q[DW-1:WIDTH] : prod_q[DW-1:WIDTH];

    // Next-state and datapath update for the IDLE/CALC/FIXUP sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dvs_d   = dvs_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == OP_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (Op == OP_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end else if (op_is_div && (B == '0)) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        op_d    = Op;
                        dvs_d   = b_mag;
                        prod_d  = {{WIDTH{1'b0}}, a_mag};
                        neg_d   = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = '0;
                        state_d = ST_CALC;
`ifdef FAST_MULT_EN
                        if (!op_is_div) begin
                            prod_d  = DW'(a_mag) * DW'(b_mag);
                            state_d = ST_FIXUP;
                        end
`endif
                    end
                end
            end
            ST_CALC: begin
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                    if (!div_diff[WIDTH]) begin
                        prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    end else begin
                        prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                case (op_q)
                    OP_MADD:         {hi_d, lo_d} = hilo + prod_s;
                    OP_MSUB:         {hi_d, lo_d} = hilo - prod_s;
                    OP_DIV, OP_DIVU: begin
                        lo_d = quot_f;
                        hi_d = rem_f;
                    end
                    default:         {hi_d, lo_d} = prod_s;
                endcase
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dvs_q   <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dvs_q   <= dvs_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: stimulus pushes expected HI/LO/DivByZero and Done cycle
// into a queue; a monitor on the falling edge pops and compares whenever Done is high.
// Also checks reset values, Busy duration, dropped Start during Busy and reset abort.
module tb_hilo_muldiv_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;
`ifdef FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        Clk, Reset, Start, Busy, Done, DivByZero;
    logic [2:0]  Op;
    logic [31:0] A, B, HI, LO;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: Done=1 with no operation outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_hi", 64'(HI), 64'(e.hi));
                chk("sb_lo", 64'(LO), 64'(e.lo));
                chk("sb_dbz", 64'(DivByZero), 64'(e.dbz));
                chk("sb_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called #1 after a rising edge; the Start is sampled at the next edge (E0).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edbz, input int lat);
        exp_t e;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dbz = edbz;
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = OP_MULT;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Returns in the cycle Done is high, counting Busy cycles on the way.
    task automatic wait_done(output int busy_n);
        int t;
        busy_n = 0;
        t = 0;
        while (!Done && t < 100) begin
            if (Busy) busy_n++;
            @(posedge Clk);
            #1;
            t++;
        end
        if (!Done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no Done within 100 cycles (t=%0t)", $time);
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input int lat);
        int bn;
        start_op(op, a, b, 1'b1, ehi, elo, edbz, lat);
        wait_done(bn);
        chk({name, "_busy_cycles"}, 64'(bn), 64'(lat));
    endtask

    initial begin
        int bn;
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 3'b000;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hi", 64'(HI), 64'h0);
        chk("rst_lo", 64'(LO), 64'h0);
        chk("rst_busy", 64'(Busy), 64'h0);
        chk("rst_done", 64'(Done), 64'h0);
        chk("rst_dbz", 64'(DivByZero), 64'h0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Largest unsigned product, then one idle cycle to see Done drop.
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT);
        wait_done(bn);
        chk("multu_busy_cycles", 64'(bn), 64'(MUL_LAT));
        @(posedge Clk);
        #1;
        chk("done_single_pulse", 64'(Done), 64'h0);
        chk("idle_after_done", 64'(Busy), 64'h0);

        // Back-to-back operations, each started in the previous Done cycle.
        run("mult",     OP_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
        run("madd",     OP_MADD,  32'd2,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFF5, 1'b0, MUL_LAT);
        run("div_neg",  OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, DIV_LAT);
        run("divu",     OP_DIVU,  32'd100,      32'd101,      32'd100,      32'd0,        1'b0, DIV_LAT);
        run("div_zero", OP_DIV,   32'd5,        32'd0,        32'd100,      32'd0,        1'b1, 0);
        run("mthi",     OP_MTHI,  32'h1234,     32'd9,        32'h1234,     32'd0,        1'b0, 0);
        run("msub",     OP_MSUB,  32'd3,        32'hFFFFFFFC, 32'h1234,     32'h0000000C, 1'b0, MUL_LAT);
        run("div_ovf",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, DIV_LAT);
        run("mtlo",     OP_MTLO,  32'h55,       32'd0,        32'h0,        32'h55,       1'b0, 0);
        run("div_rsgn", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, DIV_LAT);

        // A Start during Busy is dropped: LO must not take 0xAA and no extra Done appears.
        start_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b1, 32'hF, 32'h0FFFFFFF, 1'b0, DIV_LAT);
        repeat (5) begin
            @(posedge Clk);
            #1;
        end
        Start = 1'b1;
        Op    = OP_MTLO;
        A     = 32'hAA;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        chk("busy_start_dropped_lo", 64'(LO), 64'hFFFFFFFD);
        chk("busy_still_high", 64'(Busy), 64'h1);
        wait_done(bn);

        run("multu_carry", OP_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0, MUL_LAT);
        @(posedge Clk);
        #1;

        // Reset at iteration 10 of a divide, with a Start in the same cycle.
        start_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        Start = 1'b1;
        Op    = OP_MTHI;
        A     = 32'h55;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Reset = 1'b0;
        chk("abort_busy", 64'(Busy), 64'h0);
        chk("abort_done", 64'(Done), 64'h0);
        chk("abort_hi", 64'(HI), 64'h0);
        chk("abort_lo", 64'(LO), 64'h0);
        repeat (40) begin
            @(posedge Clk);
            #1;
        end
        chk("abort_no_late_hi", 64'(HI), 64'h0);
        chk("abort_no_late_busy", 64'(Busy), 64'h0);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multicycle multiply/divide responder that owns the HI/LO register pair. The EX stage issues a mult/div/move-to request with a one-cycle Start pulse; the unit iterates, then commits the 64-bit result to HI/LO and pulses Done. The pipeline stalls mfhi/mflo and further mult/div while Busy=1. HI/LO feed the ALU's HI/LO inputs and the mfhi/mflo forwarding path.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request strobe
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
A  input  WIDTH  rs operand; dividend or multiplicand
B  input  WIDTH  rt operand; divisor or multiplier
Busy  output  1  operation in progress; new Start is ignored
Done  output  1  one-cycle pulse when HI/LO are committed
DivByZero  output  1  valid with Done; DIV/DIVU with B=0
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (sampled at an edge) has priority over all other inputs, including Start in the same cycle.
  - HI=0, LO=0, Busy=0, Done=0, DivByZero=0, state=IDLE.
  - An operation in flight is aborted; HI/LO are not written.
- States: IDLE, CALC, FIXUP.
- IDLE: Start is accepted only when Busy=0. Let E0 be the edge that samples Start=1. Op and operands are captured at E0; later changes on A, B or Op have no effect.
  - MTHI/MTLO: HI<=A (or LO<=A) at E0. Busy stays 0. Done=1 for the cycle after E0.
  - DIV/DIVU with B=0: HI and LO unchanged. Busy stays 0. Done=1 and DivByZero=1 for the cycle after E0.
  - All other Ops: go to CALC with counter=0. Busy=1 from E0 onward.
- Signed ops (MULT, DIV, MADD, MSUB): operands are converted to magnitudes at E0 and the result signs are recorded.
- CALC: one iteration per cycle for exactly WIDTH cycles (edges E1..E32 for WIDTH=32).
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - After iteration WIDTH, go to FIXUP.
- FIXUP: one cycle. Sign correction is applied, then HI/LO are written at E33.
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ; remainder takes the sign of the dividend.
  - MULT/MULTU: {HI,LO}<=product.
  - DIV/DIVU: LO<=quotient, HI<=remainder.
  - MADD: {HI,LO}<={HI,LO}+signed product. MSUB: {HI,LO}<={HI,LO}-signed product. Both wrap mod 2^64.
  - At E33: Busy<=0, Done<=1 (cycle after E33 only), state<=IDLE.
- Total latency for iterative ops: 33 edges from Start to HI/LO visible. Busy=1 for 33 cycles.
- Done and DivByZero deassert the cycle after their pulse. DivByZero=0 on every non-div-by-zero Done.
- Start while Busy=1 is dropped; there is no queueing and no error flag.
- A Start in the cycle Done=1 (Busy=0) is accepted normally. Back-to-back operations have no bubble beyond Done.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- HI/LO hold their value in every cycle they are not explicitly written.

Optional Feature:
FAST_MULT_EN:
- Defined: MULT/MULTU/MADD/MSUB bypass CALC. The product comes from a single-cycle native multiply; FIXUP happens in the cycle after E0, so HI/LO are written at E1 and Done=1 for the cycle after E1. Busy=1 for one cycle. Divide stays iterative with unchanged latency.
- Undefined: all multiplies use the 33-edge iterative path as specified.

Test Plan:
- Reset then MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy=1 for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, Done pulses once.
- MULT A=-7 (0xFFFFFFF9), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MADD A=2, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF5.
- DIV A=-100, B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). DIVU A=100, B=101 -> LO=0, HI=100.
- DIV A=5, B=0 -> the next cycle has Done=1 and DivByZero=1 with Busy never high; HI/LO keep their prior values. MTHI A=0x1234 -> HI=0x1234 after one edge.
- Start a DIVU and assert Reset at iteration 10 -> the next cycle shows Busy=0, Done=0, HI=LO=0, and no late Done.
- A Start pulsed during Busy with Op=MTLO, A=0xAA is ignored (LO unchanged). A Start in the Done cycle is accepted.
